// File: rtl/demuxpar.sv
// demuxpar: receive-side de-rotator for the word-rotating parallel mux.
// Stage 1 captures the beat, stage 2 registers the de-rotated word order
// and the lock FSM's verdict for that beat.

// Selects one output word from the rotated bus for a given rotation.
module demuxpar_word #(
   parameter int BUS_SIZE  = 32,
   parameter int WORD_SIZE = 4,
   parameter int WORD_NUM  = BUS_SIZE / WORD_SIZE,
   parameter int ROT_W     = (WORD_NUM > 1) ? $clog2(WORD_NUM) : 1,
   parameter int IDX       = 0
) (
   input  logic [BUS_SIZE-1:0]  bus,
   input  logic [ROT_W-1:0]     rot,
   output logic [WORD_SIZE-1:0] word
);

   // Output word IDX comes from input word (IDX+rot) mod WORD_NUM.
   always_comb begin
      word = '0;
      for (int k = 0; k < WORD_NUM; k++)
         if (rot == ROT_W'(k))
            word = bus[((IDX + k) % WORD_NUM) * WORD_SIZE +: WORD_SIZE];
   end

endmodule

module demuxpar #(
   parameter int BUS_SIZE      = 32,
   parameter int WORD_SIZE     = 4,
   parameter int LOCK_COUNT    = 3,
   parameter int ERR_CNT_WIDTH = 8,
   localparam int WORD_NUM     = BUS_SIZE / WORD_SIZE
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [BUS_SIZE-1:0]      data_in,
   input  logic [WORD_NUM-1:0]      control_in,
   input  logic                     error_in,
   output logic [BUS_SIZE-1:0]      data_out,
   output logic                     valid_out,
   output logic                     error_out,
   output logic                     locked,
   output logic [ERR_CNT_WIDTH-1:0] err_count
);

   localparam int ROT_W = (WORD_NUM > 1) ? $clog2(WORD_NUM) : 1;
   localparam int CNT_W = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;

   typedef enum logic [1:0] {SEARCH, LOCKED, HOLD} state_t;

   typedef struct packed {
      logic [BUS_SIZE-1:0] data;
      logic [WORD_NUM-1:0] ctrl;
      logic                err;
   } beat_t;

   beat_t               s1;
   logic                s1_vld;   // stage 1 holds a beat sampled out of reset
   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic                one_hot;
   logic                good;
   logic [ROT_W-1:0]    rot;
   logic [BUS_SIZE-1:0] derot;

   // Stage 1: capture every beat; reset drops whatever was in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1     <= '0;
         s1_vld <= 1'b0;
      end else begin
         s1     <= '{data: data_in, ctrl: control_in, err: error_in};
         s1_vld <= 1'b1;
      end
   end

   // Classify the stage-1 beat and locate the position of original word 0.
   always_comb begin
      one_hot = (s1.ctrl != '0) && ((s1.ctrl & (s1.ctrl - 1'b1)) == '0);
      good    = one_hot && !s1.err;
      rot     = '0;
      for (int k = 0; k < WORD_NUM; k++)
         if (s1.ctrl[k]) rot = ROT_W'(k);
   end

   for (genvar i = 0; i < WORD_NUM; i++) begin : g_word
      demuxpar_word #(
         .BUS_SIZE (BUS_SIZE),
         .WORD_SIZE(WORD_SIZE),
         .WORD_NUM (WORD_NUM),
         .ROT_W    (ROT_W),
         .IDX      (i)
      ) u_word (
         .bus (s1.data),
         .rot (rot),
         .word(derot[i*WORD_SIZE +: WORD_SIZE])
      );
   end

   // Stage 2 plus lock FSM: accept/reject the beat and register all outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= SEARCH;
         cnt       <= '0;
         data_out  <= '0;
         valid_out <= 1'b0;
         error_out <= 1'b0;
         locked    <= 1'b0;
         err_count <= '0;
      end else begin
         valid_out <= 1'b0;
         error_out <= 1'b0;
         if (s1_vld) begin
            case (state)
               SEARCH: begin
                  if (!good) begin
                     cnt <= '0;
                  end else if (cnt == CNT_W'(LOCK_COUNT - 1)) begin
                     data_out  <= derot;
                     valid_out <= 1'b1;
                     state     <= LOCKED;
                     locked    <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               LOCKED: begin
                  if (good) begin
                     data_out  <= derot;
                     valid_out <= 1'b1;
                  end else begin
                     error_out <= 1'b1;
                     state     <= HOLD;
                     if (err_count != '1) err_count <= err_count + 1'b1;
                  end
               end
               HOLD: begin
                  if (good) begin
                     data_out  <= derot;
                     valid_out <= 1'b1;
                     state     <= LOCKED;
                  end else begin
                     error_out <= 1'b1;
                     cnt       <= '0;
                     state     <= SEARCH;
                     locked    <= 1'b0;
                     if (err_count != '1) err_count <= err_count + 1'b1;
                  end
               end
               default: begin
                  state  <= SEARCH;
                  cnt    <= '0;
                  locked <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_demuxpar.sv
// Directed bench for demuxpar: lock acquisition, per-beat de-rotation,
// error/hold handling, error counter saturation and mid-stream reset.
module tb_demuxpar;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] data_in;
   logic [7:0]  control_in;
   logic        error_in;
   logic [31:0] data_out;
   logic        valid_out;
   logic        error_out;
   logic        locked;
   logic [7:0]  err_count;

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] ROT1 = 32'h6543_2107;  // original order rotated for ctrl bit 1
   localparam logic [31:0] ROT7 = 32'h0765_4321;  // for ctrl bit 7
   localparam logic [31:0] ROT0 = 32'h7654_3210;  // for ctrl bit 0
   localparam logic [31:0] ORIG = 32'h7654_3210;

   demuxpar dut (
      .clk       (clk),
      .reset     (reset),
      .data_in   (data_in),
      .control_in(control_in),
      .error_in  (error_in),
      .data_out  (data_out),
      .valid_out (valid_out),
      .error_out (error_out),
      .locked    (locked),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   // Apply one beat and advance past the next rising edge.
   task automatic drive(input logic [31:0] d, input logic [7:0] c, input logic e);
      data_in    = d;
      control_in = c;
      error_in   = e;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic ev, input logic [31:0] ed,
                      input logic ee, input logic el, input logic [7:0] ec);
      checks++;
      assert (valid_out === ev) else begin
         errors++;
         $error("FAIL %s valid_out: got %b want %b", tag, valid_out, ev);
      end
      checks++;
      assert (data_out === ed) else begin
         errors++;
         $error("FAIL %s data_out: got %h want %h", tag, data_out, ed);
      end
      checks++;
      assert (error_out === ee) else begin
         errors++;
         $error("FAIL %s error_out: got %b want %b", tag, error_out, ee);
      end
      checks++;
      assert (locked === el) else begin
         errors++;
         $error("FAIL %s locked: got %b want %b", tag, locked, el);
      end
      checks++;
      assert (err_count === ec) else begin
         errors++;
         $error("FAIL %s err_count: got %0d want %0d", tag, err_count, ec);
      end
   endtask

   initial begin
      reset = 1'b1;
      drive(32'h0, 8'h00, 1'b0);
      drive(32'h0, 8'h00, 1'b0);
      chk("reset", 1'b0, 32'h0, 1'b0, 1'b0, 8'd0);

      reset = 1'b0;
      drive(32'h0, 8'h00, 1'b0);
      drive(32'h0, 8'h00, 1'b0);
      chk("idle_search", 1'b0, 32'h0, 1'b0, 1'b0, 8'd0);

      // Acquire lock: three good beats, rotation 1.
      drive(ROT1, 8'b0000_0010, 1'b0);
      drive(ROT1, 8'b0000_0010, 1'b0);
      chk("search_beat1", 1'b0, 32'h0, 1'b0, 1'b0, 8'd0);
      drive(ROT1, 8'b0000_0010, 1'b0);
      chk("search_beat2", 1'b0, 32'h0, 1'b0, 1'b0, 8'd0);
      drive(ROT7, 8'b1000_0000, 1'b0);
      chk("lock_beat3", 1'b1, ORIG, 1'b0, 1'b1, 8'd0);
      drive(ROT0, 8'b0000_0001, 1'b0);
      chk("rot7", 1'b1, ORIG, 1'b0, 1'b1, 8'd0);

      // Single upstream error while locked: pulse, HOLD, then recover.
      drive(32'hDEAD_BEEF, 8'b0000_0010, 1'b1);
      chk("rot0", 1'b1, ORIG, 1'b0, 1'b1, 8'd0);
      drive(32'h1234_5670, 8'b0000_0001, 1'b0);
      chk("err_in_pulse", 1'b0, ORIG, 1'b1, 1'b1, 8'd1);
      drive(32'h0, 8'b0000_0011, 1'b0);
      chk("hold_recover", 1'b1, 32'h1234_5670, 1'b0, 1'b1, 8'd1);

      // Two consecutive bad framings drop lock.
      drive(32'h0, 8'b0000_0000, 1'b0);
      chk("multi_hot", 1'b0, 32'h1234_5670, 1'b1, 1'b1, 8'd2);
      drive(ROT1, 8'b0000_0010, 1'b0);
      chk("zero_ctrl_unlock", 1'b0, 32'h1234_5670, 1'b1, 1'b0, 8'd3);
      drive(ROT1, 8'b0000_0010, 1'b0);
      chk("relock_g1", 1'b0, 32'h1234_5670, 1'b0, 1'b0, 8'd3);
      drive(ROT1, 8'b0000_0010, 1'b0);
      chk("relock_g2", 1'b0, 32'h1234_5670, 1'b0, 1'b0, 8'd3);
      drive(ROT1, 8'b0000_0010, 1'b0);
      chk("relock_g3", 1'b1, ORIG, 1'b0, 1'b1, 8'd3);

      // 300 bad beats, each followed by a good one to bounce LOCKED/HOLD.
      for (int i = 0; i < 300; i++) begin
         drive(ROT1, 8'b0000_0000, 1'b0);
         drive(ROT1, 8'b0000_0010, 1'b0);
      end
      drive(ROT1, 8'b0000_0010, 1'b0);
      chk("saturate", 1'b1, ORIG, 1'b0, 1'b1, 8'd255);
      drive(ROT1, 8'b0000_0000, 1'b0);
      drive(ROT1, 8'b0000_0010, 1'b0);
      chk("no_wrap", 1'b0, ORIG, 1'b1, 1'b1, 8'd255);

      // Reset while locked with beats in flight.
      drive(ROT7, 8'b1000_0000, 1'b0);
      reset = 1'b1;
      drive(ROT7, 8'b1000_0000, 1'b0);
      chk("midreset", 1'b0, 32'h0, 1'b0, 1'b0, 8'd0);
      reset = 1'b0;
      drive(ROT7, 8'b1000_0000, 1'b0);
      chk("post_reset_flush", 1'b0, 32'h0, 1'b0, 1'b0, 8'd0);
      drive(ROT7, 8'b1000_0000, 1'b0);
      chk("post_reset_g1", 1'b0, 32'h0, 1'b0, 1'b0, 8'd0);
      drive(ROT7, 8'b1000_0000, 1'b0);
      chk("post_reset_g2", 1'b0, 32'h0, 1'b0, 1'b0, 8'd0);
      drive(ROT7, 8'b1000_0000, 1'b0);
      chk("post_reset_lock", 1'b1, ORIG, 1'b0, 1'b1, 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
